datapath_sequencer: RTL
=======================

// Module: datapath_sequencer
// PURPOSE
//   Control-side counterpart of the register-file/ALU datapath: fetches 32-bit
//   instructions over a simple request/valid memory port. Decodes RV32I R-type
//   (OP, opcode 7'b0110011) and drives the datapath's RegWrite, ALUControl,
//   rs1, rs2 and rd. It sequences one instruction at a time with a multi-cycle FSM.
// PARAMETERS
//   RESET_PC    32'h0000_0000   PC value loaded on reset
//   MAX_WAIT    16              imem wait cycles before timeout error (>=1)
// PORTS
//   clk          in   1   clock, all state updates on rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   run          in   1   level; 1 = fetch/execute instructions, 0 = halt at next IDLE
//   imem_req     out  1   instruction fetch request
//   imem_addr    out  32  fetch address (= pc)
//   imem_valid   in   1   fetch data valid this cycle
//   imem_rdata   in   32  fetched instruction
//   RegWrite     out  1   datapath register write enable
//   ALUControl   out  4   datapath ALU operation
//   rs1, rs2, rd out  5   datapath register addresses
//   pc           out  32  address of current/next instruction
//   illegal      out  1   sticky: non-R-type or bad funct7 seen
//   timeout      out  1   sticky: imem_valid absent for MAX_WAIT cycles
//   retired      out  32  count of instructions that wrote a register
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, imem_req=0, RegWrite=0,
//     ALUControl=0, rs1=rs2=rd=0, illegal=0, timeout=0, retired=0. Reset
//     mid-fetch abandons the request; a late imem_valid after reset is ignored.
//   FSM states: IDLE -> FETCH -> DECODE -> EXEC -> WB -> IDLE.
//   IDLE: imem_req=0. If run=1 && timeout=0, go to FETCH next cycle.
//   FETCH: imem_req=1, imem_addr=pc, held stable until imem_valid=1. On imem_valid,
//     capture imem_rdata into instr, drop imem_req next cycle, go to DECODE.
//     The wait counter counts cycles in FETCH without valid. When it reaches MAX_WAIT,
//     set timeout, drop imem_req and go to IDLE. In IDLE, timeout blocks further fetch
//     until reset.
//   DECODE: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7];
//     ALUControl={instr[30],instr[14:12]}.
//     Legal iff opcode==7'b0110011 and funct7 in {7'h00, 7'h20}. funct7=7'h20 is
//     legal only with funct3 in {000,101}.
//     ALUControl map: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU,
//     0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
//   EXEC: outputs held; one settle cycle for the combinational regfile read and
//     the ALU.
//   WB: RegWrite=1 for exactly this one cycle iff legal && rd!=0. rd==0 never
//     asserts RegWrite. retired increments (wraps mod 2^32) when RegWrite=1.
//     Illegal instruction: RegWrite=0, illegal<=1 (sticky).
//     pc<=pc+4 (mod 2^32 wrap) in all WB cases. Next state is IDLE.
//   rs1/rs2/rd/ALUControl change only on entry to DECODE. They hold through
//     EXEC, WB and IDLE.
//   run deasserted mid-instruction: current instruction completes through WB,
//     then the FSM stays in IDLE. Min instruction latency: 5 cycles with 0-wait
//     imem (IDLE, FETCH, DECODE, EXEC, WB).
//   imem_valid outside FETCH is ignored.
// TESTING
//   1. Reset, run=1, imem returns 32'h002081B3 (add x3,x1,x2) with 0 wait ->
//      imem_addr=0, then rs1=1, rs2=2, rd=3, ALUControl=0000, a single RegWrite
//      pulse in WB, pc=4, retired=1.
//   2. 32'h402081B3 (sub x3,x1,x2) -> ALUControl=1000. 32'h4020D1B3 (sra) ->
//      1101. 32'h0020F1B3 (and) -> 0111. Each gives one RegWrite pulse.
//   3. 32'h00000033 (add x0,x0,x0) -> no RegWrite, retired unchanged, pc+4.
//      32'h00100093 (addi) -> illegal=1, no RegWrite, pc+4.
//   4. imem_valid delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles,
//      correct decode. No valid for MAX_WAIT=16 cycles -> timeout=1, FSM parks in IDLE.
//   5. rst_n pulsed low mid-FETCH and in WB -> all outputs at reset values
//      immediately (async). No RegWrite leaks. pc=RESET_PC.
//   6. Start from pc=32'hFFFF_FFFC, one legal instruction -> pc wraps to 0.
//      Drop run during EXEC -> WB completes, then the FSM idles with imem_req=0.

Source files
------------

// File: rtl/datapath_sequencer_if.sv
// Instruction-memory request/valid port between the sequencer and its fetch source.
interface datapath_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle fetch/decode sequencer for RV32I R-type instructions driving a regfile/ALU datapath.
// One instruction at a time: IDLE -> FETCH -> DECODE -> EXEC -> WB -> IDLE.
module datapath_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  datapath_sequencer_if.master        imem,
  output logic                        RegWrite,
  output logic [3:0]                  ALUControl,
  output logic [4:0]                  rs1,
  output logic [4:0]                  rs2,
  output logic [4:0]                  rd,
  output logic [31:0]                 pc,
  output logic                        illegal,
  output logic                        timeout,
  output logic [31:0]                 retired
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     retired_q, retired_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;
  logic            fetch_req;
  logic            write_en;
  logic            legal;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  // Decoded fields come straight from the captured instruction, so they only
  // change when a new instruction is latched at the FETCH -> DECODE edge.
  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  always_comb begin
    legal = 1'b0;
    if (opcode == 7'b0110011) begin
      if (funct7 == 7'h00) begin
        legal = 1'b1;
      end else if (funct7 == 7'h20) begin
        legal = (funct3 == 3'b000) || (funct3 == 3'b101);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    fetch_req = 1'b0;
    write_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run && !timeout_q) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        fetch_req = 1'b1;
        if (imem.imem_valid) begin
          instr_d = imem.imem_rdata;
          wait_d  = '0;
          state_d = StDecode;
        end else if (wait_q == CntW'(MAX_WAIT - 1)) begin
          // This is the MAX_WAIT-th cycle without data: give up and park.
          timeout_d = 1'b1;
          wait_d    = '0;
          state_d   = StIdle;
        end else begin
          wait_d = wait_q + CntW'(1);
        end
      end
      StDecode: begin
        state_d = StExec;
      end
      StExec: begin
        state_d = StWb;
      end
      StWb: begin
        write_en = legal && (instr_q[11:7] != 5'd0);
        if (write_en) begin
          retired_d = retired_q + 32'd1;
        end
        if (!legal) begin
          illegal_d = 1'b1;
        end
        pc_d    = pc_q + 32'd4;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign imem.imem_req  = fetch_req;
  assign imem.imem_addr = pc_q;

  assign RegWrite   = write_en;
  assign ALUControl = {instr_q[30], instr_q[14:12]};
  assign rs1        = instr_q[19:15];
  assign rs2        = instr_q[24:20];
  assign rd         = instr_q[11:7];
  assign pc         = pc_q;
  assign illegal    = illegal_q;
  assign timeout    = timeout_q;
  assign retired    = retired_q;

endmodule
